// File: rtl/control_fsm.sv
// Multi-cycle control unit for the 16-bit datapath: sequences each instruction
// through FETCH/DECODE/EXEC/MEM/WB/BR and drives every datapath control input.
module control_fsm #(
  parameter int MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [6:0] funct7,
  output logic [6:0] alu_op,
  output logic       sel1,
  output logic       sel2,
  output logic       re,
  output logic       wr,
  output logic       reg_wrt,
  output logic       pc_sel,
  output logic       im_select,
  output logic       branch,
  output logic       illegal
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_BR     = 3'd6
  } state_t;

  localparam logic [2:0] CL_R   = 3'd0;
  localparam logic [2:0] CL_I   = 3'd1;
  localparam logic [2:0] CL_LD  = 3'd2;
  localparam logic [2:0] CL_ST  = 3'd3;
  localparam logic [2:0] CL_BR  = 3'd4;
  localparam logic [2:0] CL_ILL = 3'd5;

  localparam logic [3:0] MEM_WAIT_C = 4'(MEM_WAIT);
  localparam logic [6:0] ALU_ADD    = 7'b0000000;
  localparam logic [6:0] ALU_SUB    = 7'b0100000;

  function automatic logic [2:0] decode_class(input logic [6:0] op);
    logic [2:0] cls;
    case (op)
      7'b0110011: cls = CL_R;
      7'b0010011: cls = CL_I;
      7'b0000011: cls = CL_LD;
      7'b0100011: cls = CL_ST;
      7'b1100011: cls = CL_BR;
      default:    cls = CL_ILL;
    endcase
    return cls;
  endfunction

  state_t     state_r, next_state_s;
  logic [2:0] cls_r;
  logic [6:0] f7_r;
  logic [3:0] cnt_r;
  logic [2:0] cls_in_s;
  logic       imm_s;
  logic [6:0] exec_alu_s;

  logic [6:0] alu_op_s, alu_op_r;
  logic       sel1_s, sel1_r, sel2_s, sel2_r, re_s, re_r, wr_s, wr_r;
  logic       reg_wrt_s, reg_wrt_r, pc_sel_s, pc_sel_r;
  logic       im_select_s, im_select_r, branch_s, branch_r, illegal_s, illegal_r;

  // Opcode is captured on the edge entering DECODE so the DECODE-cycle flags can be registered
  assign cls_in_s   = decode_class(opcode);
  assign imm_s      = (cls_r == CL_I) || (cls_r == CL_LD) || (cls_r == CL_ST);
  assign exec_alu_s = (cls_r == CL_R) ? f7_r : ALU_ADD;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Instruction class and funct7 latch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cls_r <= CL_R;
      f7_r  <= 7'd0;
    end else if (next_state_s == ST_DECODE) begin
      cls_r <= cls_in_s;
      f7_r  <= funct7;
    end else begin
      cls_r <= cls_r;
      f7_r  <= f7_r;
    end
  end

  // Memory wait counter: loaded on MEM entry, counts down while in MEM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= 4'd0;
    end else if ((next_state_s == ST_MEM) && (state_r != ST_MEM)) begin
      cnt_r <= MEM_WAIT_C;
    end else if ((state_r == ST_MEM) && (cnt_r != 4'd0)) begin
      cnt_r <= cnt_r - 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = ST_FETCH;
    case (state_r)
      ST_IDLE:   next_state_s = ST_FETCH;
      ST_FETCH:  next_state_s = ST_DECODE;
      ST_DECODE: begin
        case (cls_r)
          CL_R, CL_I, CL_LD, CL_ST: next_state_s = ST_EXEC;
          CL_BR:                    next_state_s = ST_BR;
          default:                  next_state_s = ST_FETCH;
        endcase
      end
      ST_EXEC: begin
        case (cls_r)
          CL_R, CL_I:   next_state_s = ST_WB;
          CL_LD, CL_ST: next_state_s = ST_MEM;
          default:      next_state_s = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (cnt_r != 4'd0) begin
          next_state_s = ST_MEM;
        end else if (cls_r == CL_LD) begin
          next_state_s = ST_WB;
        end else begin
          next_state_s = ST_FETCH;
        end
      end
      ST_WB:   next_state_s = ST_FETCH;
      ST_BR:   next_state_s = ST_FETCH;
      default: next_state_s = ST_FETCH;
    endcase
  end

  // Output values for the state about to be entered
  always_comb begin
    alu_op_s    = 7'd0;
    sel1_s      = 1'b0;
    sel2_s      = 1'b0;
    re_s        = 1'b0;
    wr_s        = 1'b0;
    reg_wrt_s   = 1'b0;
    pc_sel_s    = 1'b0;
    im_select_s = 1'b0;
    branch_s    = 1'b0;
    illegal_s   = 1'b0;
    case (next_state_s)
      ST_FETCH:  pc_sel_s  = 1'b1;
      ST_DECODE: illegal_s = (cls_in_s == CL_ILL);
      ST_EXEC: begin
        alu_op_s    = exec_alu_s;
        sel1_s      = imm_s;
        im_select_s = imm_s;
      end
      ST_MEM: begin
        alu_op_s    = exec_alu_s;
        sel1_s      = imm_s;
        im_select_s = imm_s;
        re_s        = (cls_r == CL_LD);
        wr_s        = (cls_r == CL_ST);
      end
      ST_WB: begin
        alu_op_s    = exec_alu_s;
        sel1_s      = imm_s;
        im_select_s = imm_s;
        reg_wrt_s   = 1'b1;
        sel2_s      = (cls_r == CL_LD);
        re_s        = (cls_r == CL_LD);
      end
      ST_BR: begin
        branch_s = 1'b1;
        alu_op_s = ALU_SUB;
      end
      default: pc_sel_s = 1'b0;
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_op_r    <= 7'd0;
      sel1_r      <= 1'b0;
      sel2_r      <= 1'b0;
      re_r        <= 1'b0;
      wr_r        <= 1'b0;
      reg_wrt_r   <= 1'b0;
      pc_sel_r    <= 1'b0;
      im_select_r <= 1'b0;
      branch_r    <= 1'b0;
      illegal_r   <= 1'b0;
    end else begin
      alu_op_r    <= alu_op_s;
      sel1_r      <= sel1_s;
      sel2_r      <= sel2_s;
      re_r        <= re_s;
      wr_r        <= wr_s;
      reg_wrt_r   <= reg_wrt_s;
      pc_sel_r    <= pc_sel_s;
      im_select_r <= im_select_s;
      branch_r    <= branch_s;
      illegal_r   <= illegal_s;
    end
  end

  assign alu_op    = alu_op_r;
  assign sel1      = sel1_r;
  assign sel2      = sel2_r;
  assign re        = re_r;
  assign wr        = wr_r;
  assign reg_wrt   = reg_wrt_r;
  assign pc_sel    = pc_sel_r;
  assign im_select = im_select_r;
  assign branch    = branch_r;
  assign illegal   = illegal_r;

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: three instances with MEM_WAIT 1, 3 and 0,
// each output vector checked cycle by cycle against hand-computed values.
module tb_control_fsm;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;
  localparam logic [6:0] SUB    = 7'b0100000;

  logic       clk = 1'b0;
  logic       rst       [3];
  logic [6:0] opc       [3];
  logic [6:0] f7        [3];
  logic [6:0] alu_op    [3];
  logic       sel1      [3];
  logic       sel2      [3];
  logic       re        [3];
  logic       wr        [3];
  logic       reg_wrt   [3];
  logic       pc_sel    [3];
  logic       im_select [3];
  logic       branch    [3];
  logic       illegal   [3];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = (g == 0) ? 1 : ((g == 1) ? 3 : 0);
    control_fsm #(.MEM_WAIT(W)) dut (
      .clk       (clk),
      .reset     (rst[g]),
      .opcode    (opc[g]),
      .funct7    (f7[g]),
      .alu_op    (alu_op[g]),
      .sel1      (sel1[g]),
      .sel2      (sel2[g]),
      .re        (re[g]),
      .wr        (wr[g]),
      .reg_wrt   (reg_wrt[g]),
      .pc_sel    (pc_sel[g]),
      .im_select (im_select[g]),
      .branch    (branch[g]),
      .illegal   (illegal[g])
    );
  end

  // Packing: {alu_op, sel1, sel2, re, wr, reg_wrt, pc_sel, im_select, branch, illegal}
  function automatic logic [15:0] ev(input logic [6:0] alu, input logic s1, input logic s2,
                                     input logic r, input logic w, input logic rw,
                                     input logic pc, input logic ims, input logic br,
                                     input logic ill);
    return {alu, s1, s2, r, w, rw, pc, ims, br, ill};
  endfunction

  function automatic logic [15:0] obs(input int k);
    return {alu_op[k], sel1[k], sel2[k], re[k], wr[k], reg_wrt[k], pc_sel[k],
            im_select[k], branch[k], illegal[k]};
  endfunction

  task automatic check_vec(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int k, input string tag, input logic [15:0] exp);
    @(posedge clk);
    #1;
    check_vec(tag, obs(k), exp);
  endtask

  initial begin
    logic [15:0] v_pc, v_z, v_rex, v_rwb, v_ill, v_br, v_iex, v_iwb, v_stm, v_ldm, v_ldwb;
    v_pc   = ev(7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    v_z    = 16'h0000;
    v_rex  = ev(SUB,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    v_rwb  = ev(SUB,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    v_ill  = ev(7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    v_br   = ev(SUB,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    v_iex  = ev(7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    v_iwb  = ev(7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    v_stm  = ev(7'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    v_ldm  = ev(7'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    v_ldwb = ev(7'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b0;
      opc[k] = 7'd0;
      f7[k]  = 7'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) check_vec($sformatf("reset_%0d", k), obs(k), v_z);

    // Instance 0 (MEM_WAIT=1): R, illegal, BRANCH, I, STORE, then reset mid-STORE
    opc[0] = OP_R;
    f7[0]  = SUB;
    @(negedge clk);
    rst[0] = 1'b1;
    step(0, "r_fetch", v_pc);
    step(0, "r_decode", v_z);
    step(0, "r_exec", v_rex);
    opc[0] = OP_BAD;
    f7[0]  = 7'd0;
    step(0, "r_wb", v_rwb);
    step(0, "r_next_fetch", v_pc);
    step(0, "ill_decode", v_ill);
    step(0, "ill_fetch", v_pc);
    opc[0] = OP_BR;
    step(0, "br_decode", v_z);
    step(0, "br_br", v_br);
    step(0, "br_fetch", v_pc);
    opc[0] = OP_I;
    f7[0]  = SUB;
    step(0, "i_decode", v_z);
    step(0, "i_exec", v_iex);
    step(0, "i_wb", v_iwb);
    step(0, "i_fetch", v_pc);
    opc[0] = OP_ST;
    step(0, "st1_decode", v_z);
    step(0, "st1_exec", v_iex);
    step(0, "st1_mem0", v_stm);
    step(0, "st1_mem1", v_stm);
    step(0, "st1_fetch", v_pc);
    step(0, "st2_decode", v_z);
    step(0, "st2_exec", v_iex);
    step(0, "st2_mem0", v_stm);
    rst[0] = 1'b0;
    #1;
    check_vec("rst_async", obs(0), v_z);
    for (int i = 0; i < 3; i++) step(0, $sformatf("rst_hold_%0d", i), v_z);
    @(negedge clk);
    rst[0] = 1'b1;
    step(0, "rst_fetch", v_pc);
    step(0, "rst_decode", v_z);
    step(0, "rst_exec", v_iex);

    // Instance 1 (MEM_WAIT=3): LOAD, 8-cycle instruction
    opc[1] = OP_LD;
    @(negedge clk);
    rst[1] = 1'b1;
    step(1, "ld3_fetch", v_pc);
    step(1, "ld3_decode", v_z);
    step(1, "ld3_exec", v_iex);
    for (int i = 0; i < 4; i++) step(1, $sformatf("ld3_mem%0d", i), v_ldm);
    step(1, "ld3_wb", v_ldwb);
    step(1, "ld3_fetch2", v_pc);

    // Instance 2 (MEM_WAIT=0): STORE then LOAD
    opc[2] = OP_ST;
    @(negedge clk);
    rst[2] = 1'b1;
    step(2, "st0_fetch", v_pc);
    step(2, "st0_decode", v_z);
    step(2, "st0_exec", v_iex);
    step(2, "st0_mem", v_stm);
    step(2, "st0_fetch2", v_pc);
    opc[2] = OP_LD;
    step(2, "ld0_decode", v_z);
    step(2, "ld0_exec", v_iex);
    step(2, "ld0_mem", v_ldm);
    step(2, "ld0_wb", v_ldwb);
    step(2, "ld0_fetch", v_pc);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/control_fsm.md
# control_fsm

Multi-cycle control unit for the 16-bit datapath. Consumes `opcode`/`funct7` from the datapath's instruction fetch and drives every datapath control input: `alu_op`, `sel1`, `sel2`, `re`, `wr`, `reg_wrt`, `pc_sel`, `im_select`, `branch`. It sequences each instruction through fetch, decode, execute, memory and writeback, and inserts a programmable number of data-memory wait cycles.

## Interface
Parameters:
- `MEM_WAIT`, default 1: extra cycles held in MEM (0..15).

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; low forces the reset state immediately.
- `opcode`  in  7  instruction opcode from the datapath.
- `funct7`  in  7  instruction funct7 field from the datapath.
- `alu_op`  out  7  ALU operation code.
- `sel1`  out  1  ALU B-operand mux: 0 register dataB, 1 sign-extended immediate.
- `sel2`  out  1  writeback mux: 0 ALU result, 1 data-memory output.
- `re`  out  1  data-memory read enable.
- `wr`  out  1  data-memory write enable.
- `reg_wrt`  out  1  register-file write enable.
- `pc_sel`  out  1  PC advance / instruction latch strobe.
- `im_select`  out  1  immediate-format select.
- `branch`  out  1  branch-evaluate strobe.
- `illegal`  out  1  one-cycle pulse on an unrecognised opcode.

## Operation
- Instruction classes, latched from `opcode` in DECODE:
  - R `0110011`
  - I `0010011`
  - LOAD `0000011`
  - STORE `0100011`
  - BRANCH `1100011`
  - anything else is ILLEGAL.
- `funct7` is latched with the class in DECODE.
- States and transitions:
  - FETCH -> DECODE.
  - DECODE -> EXEC (R, I, LOAD, STORE), BR (BRANCH), or FETCH (ILLEGAL, with `illegal`=1 for that cycle).
  - EXEC -> WB (R, I) or MEM (LOAD, STORE).
  - MEM -> WB (LOAD) or FETCH (STORE), once the wait counter expires.
  - WB -> FETCH.
  - BR -> FETCH.
- Outputs by state (all outputs not listed are 0):
  - FETCH: `pc_sel`=1.
  - DECODE: none.
  - EXEC: `alu_op` valid; `sel1`=1 for I/LOAD/STORE; `im_select`=1 for I/LOAD/STORE.
  - MEM: EXEC values held; `re`=1 (LOAD) or `wr`=1 (STORE).
  - WB: EXEC values held; `reg_wrt`=1; `sel2`=1 for LOAD; LOAD also keeps `re`=1.
  - BR: `branch`=1; `alu_op`=`0100000` (subtract); `sel1`=0.
- `alu_op` encoding:
  - R: latched `funct7`.
  - I/LOAD/STORE: `0000000` (add).
  - BRANCH: `0100000`.
  - Held through MEM and WB; 0 in FETCH/DECODE.
- Wait counter: 4 bits. Loaded with `MEM_WAIT` on MEM entry and decrements each MEM cycle. Exit MEM when the counter is 0, so MEM lasts `MEM_WAIT`+1 cycles.
- `opcode`/`funct7` are sampled only in DECODE; changes in other states are ignored.

## Timing
- All outputs are registered: each output takes its state's value in the same cycle the FSM occupies that state. Outputs are computed from next-state on the preceding edge.
- Reset (`reset`=0): state is FETCH-pending, counter 0, latched class R, latched `funct7` 0, and every output 0, asynchronously. The first rising edge with `reset`=1 enters FETCH (`pc_sel`=1).
- Reset asserted mid-instruction (including in MEM with `wr`=1) drops all outputs to 0 immediately. No partial writeback or write completes after reset.
- Cycles per instruction, FETCH to next FETCH exclusive:
  - R/I: 4.
  - LOAD: 5+`MEM_WAIT`.
  - STORE: 4+`MEM_WAIT`.
  - BRANCH: 3.
  - ILLEGAL: 2.
- `pc_sel` is exactly one cycle per instruction. `re` and `wr` are never high together. `reg_wrt` is never high in the same cycle as `wr`.
- `illegal` pulses for exactly the one DECODE cycle.

## Test plan
- Reset: hold `reset`=0 for 3 cycles mid-MEM of a STORE -> all outputs 0 within the reset cycle; release -> next edge gives `pc_sel`=1, then DECODE.
- R-type: `opcode`=`0110011`, `funct7`=`0100000`, `MEM_WAIT`=1 -> FETCH, DECODE, EXEC, WB. `alu_op`=`0100000` in EXEC and WB; `reg_wrt`=1 only in WB; `sel1`=0; next `pc_sel` 4 cycles after the first.
- LOAD with `MEM_WAIT`=3 -> `re`=1 for 4 MEM cycles plus WB; `sel1`=1; `sel2`=1 and `reg_wrt`=1 in WB only; 8-cycle instruction.
- STORE with `MEM_WAIT`=0 -> `wr`=1 for exactly 1 cycle; `reg_wrt` stays 0; return to FETCH; 4-cycle instruction.
- BRANCH `1100011` -> `branch`=1 for 1 cycle with `alu_op`=`0100000`; no `re`/`wr`/`reg_wrt`; 3-cycle instruction.
- Illegal `opcode`=`1111111` -> `illegal` pulses 1 cycle in DECODE, no other strobes, FETCH on the next cycle. Changing `opcode` during EXEC of a valid instruction alters no output.
